// File: rtl/fnd_scan_if.sv
// Counter-to-display link: scan strobe and value in, digit enables, segments and status out.
interface fnd_scan_if;
  logic        tick_1ms;
  logic [13:0] fndData;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;
  logic        conv_busy;

  modport master (
    output tick_1ms,
    output fndData,
    input  fndCom,
    input  fndFont,
    input  conv_busy
  );

  modport slave (
    input  tick_1ms,
    input  fndData,
    output fndCom,
    output fndFont,
    output conv_busy
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND driver: sequential double-dabble BCD conversion once per frame,
// one digit scanned per 1 ms tick, optional leading-zero blanking.
module fnd_scan_controller #(
  parameter bit LZ_BLANK = 1'b1
) (
  input logic       clk,
  input logic       rst,
  fnd_scan_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StConv = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [29:0]     sr_q, sr_d;
  logic [3:0][3:0] dig_q, dig_d;

  logic [13:0] sat_value;
  logic        sample;
  logic [29:0] sr_adj;
  logic [29:0] sr_shift;
  logic [3:0]  blank;
  logic [3:0]  cur_dig;

  assign sat_value = (bus.fndData > 14'd9999) ? 14'd9999 : bus.fndData;
  assign sample    = bus.tick_1ms && (idx_q == 2'd3) && (state_q == StIdle);

  // One double-dabble step: add-3 correction on every BCD nibble, then shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[14+4*i +: 4] >= 4'd5) begin
        sr_adj[14+4*i +: 4] = sr_q[14+4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[28:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    if (bus.tick_1ms) begin
      idx_d = idx_q + 2'd1;
    end
    case (state_q)
      StIdle: begin
        if (sample) begin
          sr_d    = {16'b0, sat_value};
          cnt_d   = 4'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 4'd1;
        // Digits latch all at once on the final iteration so no partial value is shown.
        if (cnt_q == 4'd13) begin
          dig_d   = sr_shift[29:14];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      sr_q    <= 30'd0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    blank = 4'b0000;
    if (LZ_BLANK) begin
      blank[3] = (dig_q[3] == 4'd0);
      blank[2] = blank[3] && (dig_q[2] == 4'd0);
      blank[1] = blank[2] && (dig_q[1] == 4'd0);
    end
  end

  assign cur_dig = dig_q[idx_q];

  always_comb begin
    bus.fndCom = 4'b1110;
    unique case (idx_q)
      2'd0: bus.fndCom = 4'b1110;
      2'd1: bus.fndCom = 4'b1101;
      2'd2: bus.fndCom = 4'b1011;
      2'd3: bus.fndCom = 4'b0111;
    endcase
  end

  always_comb begin
    bus.fndFont = 8'hFF;
    if (!blank[idx_q]) begin
      case (cur_dig)
        4'd0:    bus.fndFont = 8'hC0;
        4'd1:    bus.fndFont = 8'hF9;
        4'd2:    bus.fndFont = 8'hA4;
        4'd3:    bus.fndFont = 8'hB0;
        4'd4:    bus.fndFont = 8'h99;
        4'd5:    bus.fndFont = 8'h92;
        4'd6:    bus.fndFont = 8'h82;
        4'd7:    bus.fndFont = 8'hF8;
        4'd8:    bus.fndFont = 8'h80;
        4'd9:    bus.fndFont = 8'h90;
        default: bus.fndFont = 8'hFF;
      endcase
    end
  end

  assign bus.conv_busy = (state_q == StConv);

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench: directed scan sequences push expected digit/segment/busy values,
// a negedge monitor pops and compares against blanking and non-blanking instances.
module tb_fnd_scan_controller;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [13:0] data;
  logic        chk;

  int n_tests;
  int n_fail;

  typedef struct {
    string      name;
    logic [3:0] com;
    logic [7:0] font;
    logic [7:0] font_nb;
    logic       busy;
    bit         chk_busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fnd_scan_if bus_b ();
  fnd_scan_if bus_n ();

  assign bus_b.tick_1ms = tick;
  assign bus_b.fndData  = data;
  assign bus_n.tick_1ms = tick;
  assign bus_n.fndData  = data;

  fnd_scan_controller #(.LZ_BLANK(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  fnd_scan_controller #(.LZ_BLANK(1'b0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no entry, expected one");
      end else begin
        e = sb.pop_front();
        cmp(e.name, "fndCom", {4'b0, bus_b.fndCom}, {4'b0, e.com});
        cmp(e.name, "fndFont", bus_b.fndFont, e.font);
        cmp(e.name, "fndFont_nb", bus_n.fndFont, e.font_nb);
        if (e.chk_busy) cmp(e.name, "conv_busy", {7'b0, bus_b.conv_busy}, {7'b0, e.busy});
      end
    end
  end

  task automatic check(input string name, input logic [3:0] com, input logic [7:0] f,
                       input logic [7:0] fn, input int busy);
    exp_t x;
    x.name     = name;
    x.com      = com;
    x.font     = f;
    x.font_nb  = fn;
    x.busy     = (busy == 1);
    x.chk_busy = (busy >= 0);
    sb.push_back(x);
    chk = 1'b1;
    @(negedge clk);
    #1 chk = 1'b0;
  endtask

  // Tick is captured by exactly one rising edge; returns #1 after that edge.
  task automatic do_tick();
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk     = 1'b0;
    tick    = 1'b0;
    data    = 14'd0;
    rst     = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    check("reset_idx0", 4'b1110, 8'hC0, 8'hC0, 0);
    do_tick();
    check("reset_idx1", 4'b1101, 8'hFF, 8'hC0, 0);

    // 1234: sampling tick at idx 3, busy for exactly 14 clocks
    data = 14'd1234;
    do_tick();
    do_tick();
    do_tick();
    check("v1234_busy_e1", 4'b1110, 8'hC0, 8'hC0, 1);
    idle(13);
    check("v1234_busy_e13", 4'b1110, 8'hC0, 8'hC0, 1);
    idle(1);
    check("v1234_idx0", 4'b1110, 8'h99, 8'h99, 0);
    do_tick();
    check("v1234_idx1", 4'b1101, 8'hB0, 8'hB0, -1);
    do_tick();
    check("v1234_idx2", 4'b1011, 8'hA4, 8'hA4, -1);
    do_tick();
    check("v1234_idx3", 4'b0111, 8'hF9, 8'hF9, -1);
    do_tick();
    idle(15);

    // 12000 saturates to 9999
    data = 14'd12000;
    do_tick();
    do_tick();
    do_tick();
    do_tick();
    idle(14);
    check("sat_idx0", 4'b1110, 8'h90, 8'h90, 0);
    do_tick();
    check("sat_idx1", 4'b1101, 8'h90, 8'h90, -1);
    do_tick();
    check("sat_idx2", 4'b1011, 8'h90, 8'h90, -1);
    do_tick();
    check("sat_idx3", 4'b0111, 8'h90, 8'h90, -1);

    // 7: leading zeros blanked only on the LZ_BLANK=1 instance
    data = 14'd7;
    do_tick();
    idle(14);
    check("v7_idx0", 4'b1110, 8'hF8, 8'hF8, 0);
    do_tick();
    check("v7_idx1", 4'b1101, 8'hFF, 8'hC0, -1);
    do_tick();
    check("v7_idx2", 4'b1011, 8'hFF, 8'hC0, -1);
    do_tick();
    check("v7_idx3", 4'b0111, 8'hFF, 8'hC0, -1);

    // 5678, then change to 4321 mid-frame: old value held until next latch edge
    data = 14'd5678;
    do_tick();
    idle(14);
    check("v5678_idx0", 4'b1110, 8'h80, 8'h80, 0);
    do_tick();
    check("v5678_idx1", 4'b1101, 8'hF8, 8'hF8, -1);
    data = 14'd4321;
    check("hold_after_change", 4'b1101, 8'hF8, 8'hF8, 0);
    do_tick();
    check("hold_idx2", 4'b1011, 8'h82, 8'h82, -1);
    do_tick();
    check("hold_idx3", 4'b0111, 8'h92, 8'h92, -1);
    do_tick();
    check("hold_busy_e1", 4'b1110, 8'h80, 8'h80, 1);
    idle(13);
    check("hold_busy_e13", 4'b1110, 8'h80, 8'h80, 1);
    idle(1);
    check("v4321_idx0", 4'b1110, 8'hF9, 8'hF9, 0);
    do_tick();
    check("v4321_idx1", 4'b1101, 8'hA4, 8'hA4, -1);
    do_tick();
    check("v4321_idx2", 4'b1011, 8'hB0, 8'hB0, -1);
    do_tick();
    check("v4321_idx3", 4'b0111, 8'h99, 8'h99, -1);

    // 8888 with reset asserted before E+7 for 3 clocks
    data = 14'd8888;
    do_tick();
    idle(6);
    rst = 1'b0;
    check("rst_mid_conv", 4'b1110, 8'hC0, 8'hC0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_release", 4'b1110, 8'hC0, 8'hC0, 0);
    do_tick();
    check("rst_dig_clear", 4'b1101, 8'hFF, 8'hC0, -1);
    do_tick();
    do_tick();
    do_tick();
    check("v8888_busy_e1", 4'b1110, 8'hC0, 8'hC0, 1);
    // Four ticks inside CONV; the last lands at idx 3 and must be ignored
    do_tick();
    do_tick();
    do_tick();
    do_tick();
    idle(5);
    check("v8888_busy_e13", 4'b1110, 8'hC0, 8'hC0, 1);
    idle(1);
    check("v8888_idx0", 4'b1110, 8'h80, 8'h80, 0);
    do_tick();
    check("v8888_idx1", 4'b1101, 8'h80, 8'h80, 0);

    idle(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
